// File: rtl/cpu_int_pkg.sv
// rtl/cpu_int_pkg.sv - shared types, default vectors and priority encoder for the interrupt controller
package cpu_int_pkg;

  typedef enum logic [1:0] {INT_IDLE, INT_REQ, INT_SERVICE} int_state_t;

  localparam logic [7:0] VEC_RESET = 8'hFC;
  localparam logic [7:0] VEC_NMI   = 8'hFA;
  localparam logic [7:0] VEC_IRQ   = 8'hFE;

  // Lowest set bit wins; returns 0 when nothing is set.
  function automatic int prio_enc(input logic [15:0] v);
    int r;
    r = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_int_sync.sv
// rtl/cpu_int_sync.sv - per-channel synchroniser, polarity normalisation and edge detector
module cpu_int_sync #(
  parameter int   SYNC       = 2,
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic s,
  output logic rise
);

  logic [SYNC-1:0] chain;
  logic            d;

  // Flops reset to the inactive level so releasing reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= {SYNC{ACTIVE_LOW}};
      d     <= 1'b0;
    end else begin
      chain[0] <= src;
      for (int i = 1; i < SYNC; i++) chain[i] <= chain[i-1];
      d <= s;
    end
  end

  assign s    = chain[SYNC-1] ^ ACTIVE_LOW;
  assign rise = s & ~d;

endmodule

// File: rtl/cpu_int_ctrl.sv
// rtl/cpu_int_ctrl.sv - N-channel fixed-priority interrupt controller with req/ack handshake
module cpu_int_ctrl
  import cpu_int_pkg::*;
#(
  parameter int             N          = 3,
  parameter int             SYNC       = 2,
  parameter logic [N-1:0]   EDGE_MODE  = 3'b011,
  parameter logic [N-1:0]   ACTIVE_LOW = 3'b110,
  parameter logic [N-1:0]   MASKABLE   = 3'b100,
  parameter logic [N-1:0]   RESET_PEND = 3'b001,
  parameter logic [8*N-1:0] VEC_TABLE  = {VEC_IRQ, VEC_NMI, VEC_RESET},
  localparam int            IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  src,
  input  logic [N-1:0]  en,
  input  logic          i_mask,
  input  logic          ack,
  input  logic [N-1:0]  clr,
  output logic          req,
  output logic [IW-1:0] id,
  output logic [7:0]    vec,
  output logic [N-1:0]  pending
);

  int_state_t    state, state_n;
  logic          req_n;
  logic [IW-1:0] id_n, win;
  logic [7:0]    vec_n;
  logic [N-1:0]  pend_n, s, rise, elig, ack_clr;
  logic [15:0]   elig_ext;
  logic [7:0]    vec_tab [2**IW];

  for (genvar g = 0; g < N; g++) begin : g_ch
    cpu_int_sync #(.SYNC(SYNC), .ACTIVE_LOW(ACTIVE_LOW[g])) u_sync (
      .clk(clk), .reset(reset), .src(src[g]), .s(s[g]), .rise(rise[g])
    );
  end

  for (genvar g = 0; g < 2**IW; g++) begin : g_vec
    if (g < N) begin : g_used
      assign vec_tab[g] = VEC_TABLE[8*g +: 8];
    end else begin : g_pad
      assign vec_tab[g] = 8'h00;
    end
  end

  assign elig = en & (~MASKABLE | {N{~i_mask}})
              & ((EDGE_MODE & pending) | (~EDGE_MODE & s));

  always_comb begin
    elig_ext = '0;
    elig_ext[N-1:0] = elig;
    win = IW'(prio_enc(elig_ext));
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N; i++)
      ack_clr[i] = (state == INT_REQ) && ack && (id == IW'(i));
  end

  // A new edge beats any clear in the same cycle so no event is dropped.
  assign pend_n = EDGE_MODE & (rise | (pending & ~clr & ~ack_clr));

  always_comb begin
    state_n = state;
    req_n   = req;
    id_n    = id;
    vec_n   = vec;
    case (state)
      INT_IDLE: begin
        req_n = 1'b0;
        if (|elig) begin
          state_n = INT_REQ;
          req_n   = 1'b1;
          id_n    = win;
          vec_n   = vec_tab[win];
        end
      end
      INT_REQ: begin
        if (ack) begin
          state_n = INT_SERVICE;
          req_n   = 1'b0;
        end else if (!(|elig)) begin
          state_n = INT_IDLE;
          req_n   = 1'b0;
        end else begin
          req_n = 1'b1;
          id_n  = win;
          vec_n = vec_tab[win];
        end
      end
      INT_SERVICE: begin
        state_n = INT_IDLE;
        req_n   = 1'b0;
      end
      default: begin
        state_n = INT_IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INT_IDLE;
      req     <= 1'b0;
      id      <= '0;
      vec     <= 8'h00;
      pending <= RESET_PEND & EDGE_MODE;
    end else begin
      state   <= state_n;
      req     <= req_n;
      id      <= id_n;
      vec     <= vec_n;
      pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// tb/tb_cpu_int_ctrl.sv - scoreboard bench for cpu_int_ctrl against a behavioural model
module tb_cpu_int_ctrl;

  localparam int         N    = 3;
  localparam int         SYNC = 2;
  localparam logic [2:0] EDGE = 3'b011;
  localparam logic [2:0] ALOW = 3'b110;
  localparam logic [2:0] MASK = 3'b100;
  localparam logic [2:0] RPND = 3'b001;
  localparam logic [23:0] VTAB = {8'hFE, 8'hFA, 8'hFC};

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src, en, clr;
  logic       i_mask, ack;
  logic       req;
  logic [1:0] id;
  logic [7:0] vec;
  logic [2:0] pending;

  cpu_int_ctrl #(
    .N(N), .SYNC(SYNC), .EDGE_MODE(EDGE), .ACTIVE_LOW(ALOW),
    .MASKABLE(MASK), .RESET_PEND(RPND), .VEC_TABLE(VTAB)
  ) dut (
    .clk(clk), .reset(reset), .src(src), .en(en), .i_mask(i_mask),
    .ack(ack), .clr(clr), .req(req), .id(id), .vec(vec), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [1:0] id;
    logic [7:0] vec;
    logic [2:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Behavioural model: raw-sample history, pending bits, handshake phase.
  logic [2:0] m_samp [SYNC];
  logic [2:0] m_prev_s;
  logic [2:0] m_pend;
  int         m_phase;   // 0 waiting, 1 requesting, 2 cooldown
  logic       m_req;
  int         m_id;
  logic [7:0] m_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] vec_of(input int i);
    logic [23:0] t;
    t = VTAB;
    return t[8*i +: 8];
  endfunction

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_samp[j] = ALOW;
    m_prev_s = 3'b000;
    m_pend   = RPND & EDGE;
    m_phase  = 0;
    m_req    = 1'b0;
    m_id     = 0;
    m_vec    = 8'h00;
  endtask

  task automatic model_step();
    logic [2:0] s_now, rise, el, np;
    int w;
    bit any, acked;
    if (reset) begin
      model_reset();
    end else begin
      s_now = m_samp[SYNC-1] ^ ALOW;
      rise  = s_now & ~m_prev_s;
      any = 0; w = 0;
      for (int i = N-1; i >= 0; i--) begin
        el[i] = en[i] && (!MASK[i] || !i_mask) && (EDGE[i] ? m_pend[i] : s_now[i]);
        if (el[i]) begin any = 1; w = i; end
      end
      acked = (m_phase == 1) && ack;
      for (int i = 0; i < N; i++)
        np[i] = EDGE[i] && (rise[i] || (m_pend[i] && !clr[i] && !(acked && m_id == i)));
      m_pend = np;
      if (m_phase == 0) begin
        if (any) begin m_phase = 1; m_req = 1; m_id = w; m_vec = vec_of(w); end
        else m_req = 0;
      end else if (m_phase == 1) begin
        if (ack) begin m_phase = 2; m_req = 0; end
        else if (!any) begin m_phase = 0; m_req = 0; end
        else begin m_req = 1; m_id = w; m_vec = vec_of(w); end
      end else begin
        m_phase = 0; m_req = 0;
      end
      m_prev_s = s_now;
      for (int j = SYNC-1; j > 0; j--) m_samp[j] = m_samp[j-1];
      m_samp[0] = src;
    end
    exp_q.push_back('{req: m_req, id: 2'(m_id), vec: m_vec, pend: m_pend});
  endtask

  // Inputs are sampled by the model at the falling edge and by the DUT at the next rising edge.
  task automatic drive_cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("scoreboard", {req, id, vec, pending}, {e.req, e.id, e.vec, e.pend});
    end
  end

  initial begin
    bit found;
    reset = 1'b1; src = 3'b110; en = 3'b111; i_mask = 1'b0; ack = 1'b0; clr = 3'b000;
    model_reset();
    #3;
    chk("reset_state", {req, id, vec, pending}, {1'b0, 2'd0, 8'h00, 3'b001});
    repeat (2) drive_cycle();
    reset = 1'b0;
    drive_cycle();
    chk("first_req", {req, id, vec}, {1'b1, 2'd0, 8'hFC});
    ack = 1'b1;
    drive_cycle();
    ack = 1'b0;
    chk("ack_clear", {req, pending}, {1'b0, 3'b000});
    repeat (3) drive_cycle();
    chk("stay_low", req, 1'b0);

    // Level ch2 asserted, then a falling edge on ch1 preempts it.
    src = 3'b010;
    repeat (4) drive_cycle();
    chk("level_req", {req, id, vec}, {1'b1, 2'd2, 8'hFE});
    src = 3'b000;
    repeat (4) drive_cycle();
    chk("preempt", {req, id, vec}, {1'b1, 2'd1, 8'hFA});
    ack = 1'b1;
    drive_cycle();
    ack = 1'b0;
    chk("ack_pend1", {req, pending[1]}, {1'b0, 1'b0});
    repeat (2) drive_cycle();
    chk("rearb", {req, id, vec}, {1'b1, 2'd2, 8'hFE});
    i_mask = 1'b1;
    drive_cycle();
    chk("masked", {req, pending[2]}, {1'b0, 1'b0});
    i_mask = 1'b0; src = 3'b110;
    repeat (4) drive_cycle();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) src[i] = ~src[i];
        en[i]  = ($urandom_range(9) != 0);
        clr[i] = ($urandom_range(15) == 0);
      end
      i_mask = ($urandom_range(3) == 0);
      ack    = ($urandom_range(2) == 0);
      drive_cycle();
    end

    // Asynchronous reset in the middle of a request.
    ack = 1'b0; clr = 3'b000; en = 3'b111; i_mask = 1'b0; src = 3'b010;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      drive_cycle();
      if (m_req) found = 1;
    end
    chk("find_req", {31'd0, found}, 32'd1);
    src = 3'b110;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {req, id, vec, pending}, {1'b0, 2'd0, 8'h00, 3'b001});
    repeat (2) drive_cycle();
    reset = 1'b0;
    repeat (5) drive_cycle();
    chk("no_spurious", pending[2:1], 2'b00);

    @(posedge clk);
    #2;
    chk("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
